// File: rtl/conv3x3_dot_feeder.sv
// conv3x3_dot_feeder: accumulates one signed 3x3 dot product per channel (D1..D3)
// from a valid/ready tap stream and paces the shared job counter cnt so the
// downstream sum/compress register commits exactly when cnt == CNT_MAX.
// Optional build macro: FEEDER_BIAS_EN (adds bias_D1..bias_D3, preloaded on start).
module conv3x3_dot_feeder #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TAPS    = 9,
    parameter int unsigned DOT_W   = 21,
    parameter int unsigned CNT_MAX = 68,
    parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] pix_D1,
    input  logic signed [DATA_W-1:0] pix_D2,
    input  logic signed [DATA_W-1:0] pix_D3,
    input  logic signed [DATA_W-1:0] wgt_D1,
    input  logic signed [DATA_W-1:0] wgt_D2,
    input  logic signed [DATA_W-1:0] wgt_D3,
`ifdef FEEDER_BIAS_EN
    input  logic signed [15:0]       bias_D1,
    input  logic signed [15:0]       bias_D2,
    input  logic signed [15:0]       bias_D3,
`endif
    output logic [CNT_W-1:0]         cnt,
    output logic signed [DOT_W-1:0]  dot_D1,
    output logic signed [DOT_W-1:0]  dot_D2,
    output logic signed [DOT_W-1:0]  dot_D3,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned TAP_W  = $clog2(TAPS + 1);
    localparam int unsigned NCH    = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_TOP   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(CNT_MAX - 1);

    logic [1:0]               state_q, state_d;
    logic [TAP_W-1:0]         tap_q, tap_d;
    logic [CNT_W-1:0]         cnt_d;
    logic                     in_ready_d, busy_d, done_d;
    logic signed [DOT_W-1:0]  dot_q    [NCH];
    logic signed [DOT_W-1:0]  dot_d    [NCH];
    logic signed [DOT_W-1:0]  dot_init [NCH];
    logic signed [DATA_W-1:0] pix      [NCH];
    logic signed [DATA_W-1:0] wgt      [NCH];
    logic signed [PROD_W-1:0] prod     [NCH];

    assign pix[0] = pix_D1;
    assign pix[1] = pix_D2;
    assign pix[2] = pix_D3;
    assign wgt[0] = wgt_D1;
    assign wgt[1] = wgt_D2;
    assign wgt[2] = wgt_D3;

    assign dot_D1 = dot_q[0];
    assign dot_D2 = dot_q[1];
    assign dot_D3 = dot_q[2];

    // Job start value of each accumulator: bias (sign-extended) or zero
`ifdef FEEDER_BIAS_EN
    assign dot_init[0] = DOT_W'(bias_D1);
    assign dot_init[1] = DOT_W'(bias_D2);
    assign dot_init[2] = DOT_W'(bias_D3);
`else
    assign dot_init[0] = '0;
    assign dot_init[1] = '0;
    assign dot_init[2] = '0;
`endif

    // Full-width signed products, one per channel
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            prod[k] = PROD_W'(pix[k]) * PROD_W'(wgt[k]);
        end
    end

    // Next-state, counter pacing and accumulator update
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        cnt_d   = cnt;
        dot_d   = dot_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_ACCUM;
                    tap_d   = '0;
                    dot_d   = dot_init;
                end
            end
            S_ACCUM: begin
                // Never expose CNT_MAX while sums are still incomplete
                cnt_d = (cnt == CNT_STALL) ? cnt : cnt + CNT_W'(1);
                if (in_valid && in_ready) begin
                    for (int k = 0; k < NCH; k++) begin
                        dot_d[k] = dot_q[k] + DOT_W'(prod[k]);
                    end
                    tap_d = tap_q + TAP_W'(1);
                    if (tap_q == TAP_LAST) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt == CNT_TOP) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d = (state_d == S_ACCUM);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_HOLD) && (cnt_d == CNT_TOP);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                dot_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            cnt      <= cnt_d;
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
            for (int k = 0; k < NCH; k++) begin
                dot_q[k] <= dot_d[k];
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_dot_feeder.sv
// Self-checking bench for conv3x3_dot_feeder: random and directed jobs feed a
// scoreboard of expected dot products and done cycles; a monitor checks each done.
module tb_conv3x3_dot_feeder;

    localparam int DATA_W  = 8;
    localparam int DOT_W   = 21;
    localparam int CNT_MAX = 68;
    localparam int CNT_W   = 7;
    localparam int TAPS    = 9;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, busy, done;
    logic signed [DATA_W-1:0] pixv [3];
    logic signed [DATA_W-1:0] wgtv [3];
    logic signed [15:0]       bias_v [3];
    logic [CNT_W-1:0]         cnt;
    logic signed [DOT_W-1:0]  dot_D1, dot_D2, dot_D3;

    conv3x3_dot_feeder dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pix_D1   (pixv[0]),
        .pix_D2   (pixv[1]),
        .pix_D3   (pixv[2]),
        .wgt_D1   (wgtv[0]),
        .wgt_D2   (wgtv[1]),
        .wgt_D3   (wgtv[2]),
`ifdef FEEDER_BIAS_EN
        .bias_D1  (bias_v[0]),
        .bias_D2  (bias_v[1]),
        .bias_D3  (bias_v[2]),
`endif
        .cnt      (cnt),
        .dot_D1   (dot_D1),
        .dot_D2   (dot_D2),
        .dot_D3   (dot_D3),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        longint d1;
        longint d2;
        longint d3;
        int     done_cyc;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint last_dot [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d required finish earlier", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("done_cnt", cnt, CNT_MAX);
                chk("dot_D1", dot_D1, e.d1);
                chk("dot_D2", dot_D2, e.d2);
                chk("dot_D3", dot_D3, e.d3);
            end
        end
    end

    task automatic rand_taps();
        for (int k = 0; k < 3; k++) begin
            pixv[k] = DATA_W'($urandom);
            wgtv[k] = DATA_W'($urandom);
        end
    endtask

    // Idle cycles with in_valid asserted: nothing may change
    task automatic idle_check(input int n);
        repeat (n) begin
            in_valid = 1'b1;
            rand_taps();
            @(negedge clk);
            chk("idle_cnt", cnt, 0);
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_dot1", dot_D1, last_dot[0]);
            chk("idle_dot2", dot_D2, last_dot[1]);
            chk("idle_dot3", dot_D3, last_dot[2]);
        end
        in_valid = 1'b0;
    endtask

    // mode 0: directed back-to-back, 1: random bubbled, 2: late taps (stall), 3: all-ones bubbled
    task automatic run_job(input int mode, input int abort_after);
        int     s, t9, d, acc, guard;
        bit     v;
        longint sum [3];
        exp_t   e;

        idle_check(2);
        for (int k = 0; k < 3; k++) begin
`ifdef FEEDER_BIAS_EN
            bias_v[k] = (mode == 0 && k == 0) ? -16'sd100 : 16'($urandom);
`else
            bias_v[k] = '0;
`endif
            sum[k] = longint'(bias_v[k]);
        end
        start = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        guard = 0;
        t9 = 0;
        while (acc < TAPS) begin
            chk("accum_ready", in_ready, 1);
            chk("accum_busy", busy, 1);
            chk("accum_done", done, 0);
            chk("accum_cnt", cnt, (cyc - s > CNT_MAX - 1) ? CNT_MAX - 1 : cyc - s);
            if (abort_after >= 0 && acc == abort_after) begin
                rst = 1'b1;
                in_valid = 1'b0;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_cnt", cnt, 0);
                chk("abort_ready", in_ready, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_dot1", dot_D1, 0);
                chk("abort_dot2", dot_D2, 0);
                chk("abort_dot3", dot_D3, 0);
                for (int k = 0; k < 3; k++) last_dot[k] = 0;
                return;
            end
            case (mode)
                0: v = 1'b1;
                2: v = (acc < 5) ? 1'b1 : ((cyc - s >= 72) ? 1'($urandom) : 1'b0);
                default: v = 1'($urandom);
            endcase
            if (mode == 0) begin
                pixv[0] = 8'sd3;    wgtv[0] = 8'sd4;
                pixv[1] = -8'sd2;   wgtv[1] = 8'sd5;
                pixv[2] = -8'sd128; wgtv[2] = -8'sd128;
            end else if (mode == 3) begin
                for (int k = 0; k < 3; k++) begin
                    pixv[k] = 8'sd1;
                    wgtv[k] = 8'sd1;
                end
            end else begin
                rand_taps();
            end
            in_valid = v;
            start = (mode != 0) && ($urandom_range(0, 7) == 0);
            if (v) begin
                for (int k = 0; k < 3; k++) sum[k] += longint'(pixv[k]) * longint'(wgtv[k]);
                acc++;
                if (acc == TAPS) t9 = cyc + 1;
            end
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                chk("tap_timeout", guard, 0);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        d = (s + CNT_MAX > t9 + 1) ? s + CNT_MAX : t9 + 1;
        e.d1 = sum[0];
        e.d2 = sum[1];
        e.d3 = sum[2];
        e.done_cyc = d;
        sb_q.push_back(e);
        while (cyc <= d) begin
            if (cyc < d) begin
                chk("hold_ready", in_ready, 0);
                chk("hold_busy", busy, 1);
                chk("hold_done", done, 0);
            end
            in_valid = 1'($urandom);
            rand_taps();
            start = (cyc < d - 1) && ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        in_valid = 1'b0;
        chk("done_seen", sb_q.size(), 0);
        chk("end_busy", busy, 0);
        chk("end_cnt", cnt, 0);
        chk("end_done", done, 0);
        for (int k = 0; k < 3; k++) last_dot[k] = sum[k];
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pixv[k] = '0;
            wgtv[k] = '0;
            bias_v[k] = '0;
            last_dot[k] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dot1", dot_D1, 0);
        chk("rst_dot2", dot_D2, 0);
        chk("rst_dot3", dot_D3, 0);
        rst = 1'b0;

        run_job(0, -1);
        run_job(3, -1);
        run_job(2, -1);
        run_job(1, 4);
        run_job(1, -1);
        repeat (6) run_job(1, -1);
        run_job(2, -1);
        idle_check(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
